// File: rtl/cntr_bs_entry.sv
// Purpose : one-entry request hold register that steers each read/write
//           request into one of the per-type FIFOs. It prefers a FIFO whose
//           last row matches the request (row hit), then any empty FIFO.
// Latency : 1 cycle from request handshake to push when a target FIFO exists.
// Backpres: req_ready = !held || push fires. A stalled request holds the
//           entry and counts stalled cycles in stall_cnt (saturating).
// Ports   : clk/rst (async, active-high); req_* request channel from the
//           txn controller; push/valid_o/dq_o/idx_o/ra_o/ca_o go to the
//           datapath; last_ra is the last pushed row address per FIFO;
//           pop is the one-hot dequeue from the scheduler.
module cntr_bs_entry #(
    parameter int RD_FIFO_NUM  = 4,
    parameter int WR_FIFO_NUM  = 3,
    parameter int RD_FIFO_SIZE = 4,
    parameter int WR_FIFO_SIZE = 3,
    parameter int DQ           = 16,
    parameter int IDX          = 7,
    parameter int RA           = 16,
    parameter int CA           = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_type,
    input  logic [DQ-1:0]                         req_dq,
    input  logic [IDX-1:0]                        req_idx,
    input  logic [RA-1:0]                         req_ra,
    input  logic [CA-1:0]                         req_ca,
    output logic [RD_FIFO_NUM+WR_FIFO_NUM-1:0]    push,
    output logic                                  valid_o,
    output logic [DQ-1:0]                         dq_o,
    output logic [IDX-1:0]                        idx_o,
    output logic [RA-1:0]                         ra_o,
    output logic [CA-1:0]                         ca_o,
    input  logic [RA*(RD_FIFO_NUM+WR_FIFO_NUM)-1:0] last_ra,
    input  logic [RD_FIFO_NUM+WR_FIFO_NUM-1:0]    pop,
    output logic [7:0]                            stall_cnt
);

    localparam int FIFO_NUM = RD_FIFO_NUM + WR_FIFO_NUM;
    localparam int MAX_SIZE = (RD_FIFO_SIZE > WR_FIFO_SIZE) ? RD_FIFO_SIZE : WR_FIFO_SIZE;
    // One shared counter width, wide enough for the deeper FIFO type.
    localparam int CW       = $clog2(MAX_SIZE + 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             hold_type_q, hold_type_d;
    logic [DQ-1:0]    hold_dq_q, hold_dq_d;
    logic [IDX-1:0]   hold_idx_q, hold_idx_d;
    logic [RA-1:0]    hold_ra_q, hold_ra_d;
    logic [CA-1:0]    hold_ca_q, hold_ca_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]    cnt_q [FIFO_NUM];
    logic [CW-1:0]    cnt_d [FIFO_NUM];

    logic                hold_vld;
    logic                handshake;
    logic                push_fire;
    logic [FIFO_NUM-1:0] cand;
    logic [FIFO_NUM-1:0] fifo_full;
    logic [FIFO_NUM-1:0] fifo_empty;
    logic [FIFO_NUM-1:0] row_hit;
    logic [FIFO_NUM-1:0] pick;
    logic                hit_found;
    logic                emp_found;

    assign hold_vld  = (state_q == ST_HELD);
    assign push_fire = |push;
    // Ready is forced low for as long as reset is asserted.
    assign req_ready = !rst && (!hold_vld || push_fire);
    assign handshake = req_valid && req_ready;

    // Per-FIFO status from the registered counters only: a pop in this
    // cycle does not make room until the next cycle.
    always_comb begin
        cand       = '0;
        fifo_full  = '0;
        fifo_empty = '0;
        row_hit    = '0;
        for (int g = 0; g < FIFO_NUM; g++) begin
            cand[g]       = hold_type_q ? (g >= RD_FIFO_NUM) : (g < RD_FIFO_NUM);
            fifo_full[g]  = (int'(cnt_q[g]) ==
                             ((g < RD_FIFO_NUM) ? RD_FIFO_SIZE : WR_FIFO_SIZE));
            fifo_empty[g] = (cnt_q[g] == '0);
            row_hit[g]    = cand[g] && !fifo_empty[g] && !fifo_full[g] &&
                            (last_ra[g*RA +: RA] == hold_ra_q);
        end
    end

    // Lowest-index row hit wins; failing that, lowest-index empty candidate.
    always_comb begin
        pick      = '0;
        hit_found = 1'b0;
        emp_found = 1'b0;
        for (int g = 0; g < FIFO_NUM; g++) begin
            if (row_hit[g] && !hit_found) begin
                pick      = '0;
                pick[g]   = 1'b1;
                hit_found = 1'b1;
            end
        end
        if (!hit_found) begin
            for (int g = 0; g < FIFO_NUM; g++) begin
                if (cand[g] && fifo_empty[g] && !emp_found) begin
                    pick[g]   = 1'b1;
                    emp_found = 1'b1;
                end
            end
        end
    end

    assign push    = hold_vld ? pick : '0;
    assign valid_o = push_fire;

    assign dq_o      = hold_type_q ? hold_dq_q : '0;
    assign idx_o     = hold_idx_q;
    assign ra_o      = hold_ra_q;
    assign ca_o      = hold_ca_q;
    assign stall_cnt = stall_cnt_q;

    // Hold register, state and stall counter next-state.
    always_comb begin
        state_d     = state_q;
        hold_type_d = hold_type_q;
        hold_dq_d   = hold_dq_q;
        hold_idx_d  = hold_idx_q;
        hold_ra_d   = hold_ra_q;
        hold_ca_d   = hold_ca_q;
        stall_cnt_d = stall_cnt_q;
        if (handshake) begin
            // Covers both the EMPTY load and the reload on a push cycle.
            state_d     = ST_HELD;
            hold_type_d = req_type;
            hold_dq_d   = req_dq;
            hold_idx_d  = req_idx;
            hold_ra_d   = req_ra;
            hold_ca_d   = req_ca;
            stall_cnt_d = 8'd0;
        end else if (push_fire) begin
            state_d     = ST_EMPTY;
            stall_cnt_d = 8'd0;
        end else if (hold_vld && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // Occupancy: push and pop together cancel; pop on an empty FIFO is dropped.
    always_comb begin
        for (int g = 0; g < FIFO_NUM; g++) begin
            cnt_d[g] = cnt_q[g];
            if (push[g] && !pop[g]) begin
                cnt_d[g] = cnt_q[g] + CW'(1);
            end else if (!push[g] && pop[g] && (cnt_q[g] != '0)) begin
                cnt_d[g] = cnt_q[g] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            hold_type_q <= 1'b0;
            hold_dq_q   <= '0;
            hold_idx_q  <= '0;
            hold_ra_q   <= '0;
            hold_ca_q   <= '0;
            stall_cnt_q <= 8'd0;
            for (int g = 0; g < FIFO_NUM; g++) begin
                cnt_q[g] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hold_type_q <= hold_type_d;
            hold_dq_q   <= hold_dq_d;
            hold_idx_q  <= hold_idx_d;
            hold_ra_q   <= hold_ra_d;
            hold_ca_q   <= hold_ca_d;
            stall_cnt_q <= stall_cnt_d;
            for (int g = 0; g < FIFO_NUM; g++) begin
                cnt_q[g] <= cnt_d[g];
            end
        end
    end

endmodule

// File: tb/tb_cntr_bs_entry.sv
// Testbench for cntr_bs_entry: directed vector table, directed multi-cycle
// sequences (full-FIFO stall, reset mid-request, push/pop collision,
// saturation), then randomized traffic against a behavioural model.
module tb_cntr_bs_entry;

    localparam int RDN = 4;
    localparam int WRN = 3;
    localparam int FN  = 7;
    localparam int DQ  = 16;
    localparam int IDX = 7;
    localparam int RA  = 16;
    localparam int CA  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_type = 1'b0;
    logic [DQ-1:0]   req_dq = '0;
    logic [IDX-1:0]  req_idx = '0;
    logic [RA-1:0]   req_ra = '0;
    logic [CA-1:0]   req_ca = '0;
    logic [FN-1:0]   push;
    logic            valid_o;
    logic [DQ-1:0]   dq_o;
    logic [IDX-1:0]  idx_o;
    logic [RA-1:0]   ra_o;
    logic [CA-1:0]   ca_o;
    logic [RA*FN-1:0] last_ra;
    logic [FN-1:0]   pop = '0;
    logic [7:0]      stall_cnt;

    logic [RA-1:0]   lra [FN];
    int              n_chk = 0;
    int              n_fail = 0;

    cntr_bs_entry dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_dq(req_dq), .req_idx(req_idx), .req_ra(req_ra), .req_ca(req_ca),
        .push(push), .valid_o(valid_o), .dq_o(dq_o), .idx_o(idx_o),
        .ra_o(ra_o), .ca_o(ca_o), .last_ra(last_ra), .pop(pop),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: each FIFO remembers the row of its last push.
    always @(posedge clk) begin
        for (int g = 0; g < FN; g++) begin
            if (push[g]) lra[g] <= ra_o;
        end
    end

    always_comb begin
        last_ra = '0;
        for (int g = 0; g < FN; g++) last_ra[g*RA +: RA] = lra[g];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; checks happen 1 time unit later.
    task automatic drive(input logic r, input logic v, input logic t,
                         input logic [DQ-1:0] dq, input logic [IDX-1:0] idx,
                         input logic [RA-1:0] ra, input logic [FN-1:0] p);
        @(negedge clk);
        rst = r; req_valid = v; req_type = t; req_dq = dq; req_idx = idx;
        req_ra = ra; req_ca = '0; pop = p;
        #1;
    endtask

    // Single request from EMPTY, then one idle cycle where the push is checked.
    task automatic do_req(input logic t, input logic [RA-1:0] ra, input logic [FN-1:0] p,
                          input logic [FN-1:0] e, input string nm);
        drive(1'b0, 1'b1, t, 16'h0, 7'h0, ra, 7'h0);
        chk({nm, "_rdy"}, 64'(req_ready), 64'(1'b1));
        drive(1'b0, 1'b0, t, 16'h0, 7'h0, ra, p);
        chk({nm, "_push"}, 64'(push), 64'(e));
    endtask

    typedef struct {
        logic           rst, vld, typ;
        logic [DQ-1:0]  dq;
        logic [IDX-1:0] idx;
        logic [RA-1:0]  ra;
        logic [FN-1:0]  pop;
        logic [FN-1:0]  e_push;
        logic           e_rdy;
        logic           chkf;
        logic [DQ-1:0]  e_dq;
        logic [IDX-1:0] e_idx;
        logic [RA-1:0]  e_ra;
    } vec_t;

    vec_t tv [11];

    logic [RA-1:0] wra  [10];
    logic [FN-1:0] wexp [10];

    // Behavioural model state for the random phase.
    logic          m_hold, m_type;
    logic [DQ-1:0] m_dq;
    logic [IDX-1:0] m_idx;
    logic [RA-1:0] m_ra;
    logic [CA-1:0] m_ca;
    int            m_cnt [FN];
    int            m_stall;
    logic [FN-1:0] ep;
    logic          erdy, hs;
    int            lo, hi, tmp;

    function automatic int fsz(input int g);
        return (g < RDN) ? 4 : 3;
    endfunction

    initial begin
        for (int g = 0; g < FN; g++) lra[g] = '0;

        //                rst   vld   typ   dq        idx    ra        pop    e_push e_rdy chkf  e_dq      e_idx  e_ra
        tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0,    7'h00, 16'h0000, 7'h00, 7'h00, 1'b0, 1'b1, 16'h0,    7'h00, 16'h0000};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 7'h05, 16'h0012, 7'h00, 7'h00, 1'b1, 1'b1, 16'h0,    7'h00, 16'h0000};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 16'h0,    7'h06, 16'h0012, 7'h00, 7'h01, 1'b1, 1'b1, 16'h0,    7'h05, 16'h0012};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 16'h0,    7'h07, 16'h0034, 7'h00, 7'h01, 1'b1, 1'b1, 16'h0,    7'h06, 16'h0012};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 16'h0,    7'h00, 16'h0000, 7'h00, 7'h02, 1'b1, 1'b1, 16'h0,    7'h07, 16'h0034};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 16'h0,    7'h00, 16'h0000, 7'h00, 7'h00, 1'b1, 1'b0, 16'h0,    7'h00, 16'h0000};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 16'hBEEF, 7'h11, 16'h0055, 7'h00, 7'h00, 1'b1, 1'b0, 16'h0,    7'h00, 16'h0000};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 16'h0,    7'h00, 16'h0000, 7'h00, 7'h10, 1'b1, 1'b1, 16'hBEEF, 7'h11, 16'h0055};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 16'h0,    7'h00, 16'h0000, 7'h01, 7'h00, 1'b1, 1'b0, 16'h0,    7'h00, 16'h0000};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 7'h22, 16'h0012, 7'h00, 7'h00, 1'b1, 1'b0, 16'h0,    7'h00, 16'h0000};
        tv[10] = '{1'b0, 1'b0, 1'b0, 16'h0,    7'h00, 16'h0000, 7'h00, 7'h01, 1'b1, 1'b1, 16'h0,    7'h22, 16'h0012};

        for (int i = 0; i < 11; i++) begin
            drive(tv[i].rst, tv[i].vld, tv[i].typ, tv[i].dq, tv[i].idx, tv[i].ra, tv[i].pop);
            chk($sformatf("tv%0d_push", i), 64'(push), 64'(tv[i].e_push));
            chk($sformatf("tv%0d_rdy", i), 64'(req_ready), 64'(tv[i].e_rdy));
            chk($sformatf("tv%0d_valid", i), 64'(valid_o), 64'(|tv[i].e_push));
            if (tv[i].chkf) begin
                chk($sformatf("tv%0d_dq", i), 64'(dq_o), 64'(tv[i].e_dq));
                chk($sformatf("tv%0d_idx", i), 64'(idx_o), 64'(tv[i].e_idx));
                chk($sformatf("tv%0d_ra", i), 64'(ra_o), 64'(tv[i].e_ra));
            end
        end

        // Fill all write FIFOs, then stall a write until a pop frees FIFO 4.
        drive(1'b1, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        wra  = '{16'h200, 16'h200, 16'h200, 16'h300, 16'h300, 16'h300,
                 16'h400, 16'h400, 16'h400, 16'h200};
        wexp = '{7'h00, 7'h10, 7'h10, 7'h10, 7'h20, 7'h20, 7'h20, 7'h40, 7'h40, 7'h40};
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 16'h1000 + 16'(i), 7'(i), wra[i], 7'h0);
            chk($sformatf("wfill%0d_push", i), 64'(push), 64'(wexp[i]));
            chk($sformatf("wfill%0d_rdy", i), 64'(req_ready), 64'(1'b1));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 16'hCAFE, 7'h55, 16'h500, (i == 3) ? 7'h10 : 7'h00);
            chk($sformatf("wstall%0d_push", i), 64'(push), 64'(7'h00));
            chk($sformatf("wstall%0d_rdy", i), 64'(req_ready), 64'(1'b0));
            chk($sformatf("wstall%0d_cnt", i), 64'(stall_cnt), 64'(i));
        end
        drive(1'b0, 1'b1, 1'b1, 16'hCAFE, 7'h55, 16'h500, 7'h00);
        chk("wpop_push", 64'(push), 64'(7'h10));
        chk("wpop_rdy", 64'(req_ready), 64'(1'b1));
        drive(1'b0, 1'b0, 1'b1, 16'h0, 7'h0, 16'h0, 7'h00);
        chk("wreload_stall", 64'(stall_cnt), 64'(0));
        chk("wreload_ra", 64'(ra_o), 64'(16'h500));
        chk("wreload_dq", 64'(dq_o), 64'(16'hCAFE));
        chk("wreload_push", 64'(push), 64'(7'h00));

        // Reset asserted mid-cycle while a write is stalled.
        #2 rst = 1'b1;
        #1;
        chk("rst_push", 64'(push), 64'(7'h00));
        chk("rst_valid", 64'(valid_o), 64'(1'b0));
        chk("rst_rdy", 64'(req_ready), 64'(1'b0));
        chk("rst_ra", 64'(ra_o), 64'(16'h0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        chk("rst_cnt4", 64'(dut.cnt_q[4]), 64'(0));
        drive(1'b0, 1'b1, 1'b0, 16'h0, 7'h3, 16'h0077, 7'h0);
        chk("postrst_rdy", 64'(req_ready), 64'(1'b1));
        chk("postrst_push0", 64'(push), 64'(7'h00));
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        chk("postrst_push1", 64'(push), 64'(7'h01));
        chk("postrst_ra", 64'(ra_o), 64'(16'h0077));

        // Push and pop together on FIFO 2; pop on an empty FIFO 3.
        do_req(1'b0, 16'h00A1, 7'h00, 7'h02, "c22a");
        do_req(1'b0, 16'h00C2, 7'h00, 7'h04, "c22b");
        do_req(1'b0, 16'h00C2, 7'h00, 7'h04, "c22c");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        chk("cnt2_before", 64'(dut.cnt_q[2]), 64'(2));
        do_req(1'b0, 16'h00C2, 7'h04, 7'h04, "c22d");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h08);
        chk("cnt2_pushpop", 64'(dut.cnt_q[2]), 64'(2));
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        chk("cnt3_emptypop", 64'(dut.cnt_q[3]), 64'(0));
        do_req(1'b0, 16'h00D3, 7'h00, 7'h08, "c22e");

        // Eight distinct reads back-to-back with no pops.
        drive(1'b1, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 12; c++) begin
                drive(1'b0, (k < 8), 1'b0, 16'h0, 7'(k), 16'h600 + 16'(k), 7'h0);
                chk($sformatf("rd8_%0d_push", c), 64'(push),
                    64'((c >= 1 && c <= 4) ? (7'h01 << (c - 1)) : 7'h00));
                chk($sformatf("rd8_%0d_rdy", c), 64'(req_ready), 64'(c <= 4));
                if (req_valid && req_ready) k++;
            end
        end
        for (int c = 0; c < 260; c++) drive(1'b0, 1'b1, 1'b0, 16'h0, 7'h0, 16'h0699, 7'h0);
        chk("stall_sat", 64'(stall_cnt), 64'(255));
        drive(1'b0, 1'b1, 1'b0, 16'h0, 7'h0, 16'h0699, 7'h0);
        chk("stall_sat_hold", 64'(stall_cnt), 64'(255));
        chk("rd8_no_write_push", 64'(push & 7'h70), 64'(0));

        // Randomized traffic against the behavioural model.
        drive(1'b1, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 7'h0, 16'h0, 7'h0);
        m_hold = 1'b0; m_type = 1'b0; m_dq = '0; m_idx = '0; m_ra = '0; m_ca = '0;
        m_stall = 0;
        for (int g = 0; g < FN; g++) m_cnt[g] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst       = 1'b0;
            req_valid = ($urandom_range(0, 9) < 7);
            req_type  = 1'($urandom_range(0, 1));
            req_ra    = 16'h10 + 16'($urandom_range(0, 3));
            req_idx   = 7'($urandom);
            req_dq    = 16'($urandom);
            req_ca    = 10'($urandom);
            pop       = ($urandom_range(0, 9) < 4) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
            #1;
            ep = '0;
            if (m_hold) begin
                lo = m_type ? RDN : 0;
                hi = m_type ? FN : RDN;
                for (int g = lo; g < hi; g++)
                    if (ep == 0 && m_cnt[g] > 0 && m_cnt[g] < fsz(g) && lra[g] == m_ra)
                        ep = 7'(1 << g);
                for (int g = lo; g < hi; g++)
                    if (ep == 0 && m_cnt[g] == 0) ep = 7'(1 << g);
            end
            erdy = !m_hold || (ep != 0);
            chk("rnd_push", 64'(push), 64'(ep));
            chk("rnd_rdy", 64'(req_ready), 64'(erdy));
            chk("rnd_valid", 64'(valid_o), 64'(ep != 0));
            chk("rnd_ra", 64'(ra_o), 64'(m_ra));
            chk("rnd_idx", 64'(idx_o), 64'(m_idx));
            chk("rnd_ca", 64'(ca_o), 64'(m_ca));
            chk("rnd_dq", 64'(dq_o), 64'(m_type ? m_dq : 16'h0));
            chk("rnd_stall", 64'(stall_cnt), 64'(m_stall));
            hs = req_valid && erdy;
            for (int g = 0; g < FN; g++) begin
                tmp = m_cnt[g] + int'(ep[g]) - int'(pop[g]);
                m_cnt[g] = (tmp < 0) ? 0 : tmp;
            end
            if (hs) begin
                m_hold = 1'b1; m_type = req_type; m_dq = req_dq; m_idx = req_idx;
                m_ra = req_ra; m_ca = req_ca; m_stall = 0;
            end else if (ep != 0) begin
                m_hold = 1'b0; m_stall = 0;
            end else if (m_hold) begin
                m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cntr_bs_entry.md
CNTR_BS_ENTRY -- requirements
Module: cntr_bs_entry

Interface
REQ-001: Parameters (name, default, meaning):
- RD_FIFO_NUM, 4, number of read FIFOs.
- WR_FIFO_NUM, 3, number of write FIFOs.
- RD_FIFO_SIZE, 4, read FIFO depth.
- WR_FIFO_SIZE, 3, write FIFO depth.
- DQ, 16, data width.
- IDX, 7, index width.
- RA, 16, row address width.
- CA, 10, column address width.
- FIFO_NUM = RD+WR. Read FIFOs occupy indices 0..RD-1; write FIFOs occupy indices RD..FIFO_NUM-1.

REQ-002: One clock; reset is asynchronous and active-high.

REQ-003: Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- req_valid, in, 1, request valid from txn controller.
- req_ready, out, 1, request accepted when req_valid and req_ready are both high.
- req_type, in, 1, 0 = read, 1 = write.
- req_dq, in, DQ, write data.
- req_idx, in, IDX, index.
- req_ra, in, RA, row address.
- req_ca, in, CA, column address.
- push, out, FIFO_NUM, one-hot push to datapath.
- valid_o, out, 1, high whenever push is non-zero.
- dq_o, out, DQ, held data.
- idx_o, out, IDX, held index.
- ra_o, out, RA, held row address.
- ca_o, out, CA, held column address.
- last_ra, in, RA*FIFO_NUM, last pushed row address per FIFO (slice g at [g*RA +: RA]).
- pop, in, FIFO_NUM, one-hot pops from scheduler.
- stall_cnt, out, 8, saturating count of stalled cycles for the current held request.

Function
REQ-004: One-entry hold register (hold_vld plus type/dq/idx/ra/ca fields). A handshake loads the register in the same clock edge.

REQ-005: req_ready = !hold_vld || push_fire, where push_fire = |push. This gives back-to-back throughput of 1 request per cycle.

REQ-006: FSM has two states.
- EMPTY: hold_vld = 0.
- HELD: hold_vld = 1.
- EMPTY -> HELD on handshake.
- HELD -> EMPTY on push_fire without a new handshake.
- HELD -> HELD on push_fire together with a handshake (register reloaded), or on a stall.

REQ-007: Per-FIFO occupancy counter cnt[g], width $clog2(size+1), updated as cnt += push[g] - pop[g]. Simultaneous push and pop on the same FIFO leaves cnt unchanged.

REQ-008: FIFO g is full when cnt[g] == its SIZE and empty when cnt[g] == 0. Both use registered cnt; a same-cycle pop does not free space.

REQ-009: Candidate set = FIFOs matching the held type (read: 0..RD-1, write: RD..FIFO_NUM-1).

REQ-010: Selection, combinational from the HELD state, in priority order:
- (a) Lowest-index candidate that is not empty, not full, and whose last_ra slice equals ra_o (row hit).
- (b) Otherwise, lowest-index empty candidate.
- (c) Otherwise, no push (stall).

REQ-011: push is one-hot or zero and is zero in EMPTY. No bit is ever set for a full FIFO or a wrong-type FIFO.

REQ-012: dq_o, idx_o, ra_o and ca_o always reflect the hold register. dq_o is driven 0 when the held type is read.

REQ-013: stall_cnt:
- Clears on every load and every push_fire.
- Increments by 1 each HELD cycle with no push.
- Saturates at 255.

REQ-014: A pop on an empty FIFO is ignored (cnt stays 0). No underflow.

REQ-015: Latency is 1 cycle from handshake to push when a target exists.

Reset
REQ-016: While rst is high, asynchronously:
- hold_vld = 0.
- All cnt = 0.
- push = 0, valid_o = 0.
- dq_o, idx_o, ra_o, ca_o = 0.
- stall_cnt = 0.
- req_ready = 0 (forced low).

REQ-017: After rst deasserts, req_ready = 1 on the first clk cycle. A reset asserted mid-request discards the held request without any push.

Verification
REQ-018: Read with ra=0x0012 after reset -> push=7'b0000001 one cycle later; cnt[0]=1; idx_o and ra_o match the request.

REQ-019: Second read with ra=0x0012 while cnt[0]=1 and last_ra[0]=0x0012 -> push=7'b0000001 (row hit). A third read with ra=0x0034 -> push=7'b0000010.

REQ-020: Write requests pushed with all 3 write FIFOs full (cnt=3) and no row hit -> push=0 and req_ready=0; stall_cnt counts 1, 2, 3. A pop on bit 4 -> push=7'b0010000 on the next cycle and stall_cnt resets to 0.

REQ-021: req_valid held high for 8 reads with distinct ra, no pops -> reads fill FIFOs 0..3 one request each; further reads reuse row-hit FIFOs only if ra matches, otherwise stall. No push ever targets indices 4-6.

REQ-022: Simultaneous push and pop on FIFO 2 with cnt=2 -> cnt stays 2. A pop on an empty FIFO -> cnt stays 0.

REQ-023: rst pulsed while HELD with a stalled write -> push=0 immediately and hold cleared. After release, the first new request is accepted and pushed normally.
